mc_ctrl: RTL and testbench

Multi-cycle control sequencer for the MIPS datapath. It decodes `opCode`/`Funct` from the datapath's instruction register and steps each instruction through FETCH/DECODE/EXEC/MEM/WB. In each state it drives the datapath control lines, the PC/IR write enables and the memory strobes. It stalls on a shared-memory ready handshake and traps on unsupported encodings.

---
 rtl/mc_ctrl_pkg.sv | 68 ++++++
 rtl/mc_ctrl_decode.sv | 34 +++
 rtl/mc_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_mc_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared state, opcode, ALU code and instruction-class definitions
// for the multi-cycle MIPS control sequencer.
`default_nettype none

package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    RTYPE_ALU = 4'd0,
    IMM_ALU   = 4'd1,
    LOAD      = 4'd2,
    STORE     = 4'd3,
    BRANCH    = 4'd4,
    JUMP      = 4'd5,
    JAL       = 4'd6,
    JR        = 4'd7,
    ILLEGAL   = 4'd8
  } iclass_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b010;
  localparam logic [2:0] ALU_LUI  = 3'b011;
  localparam logic [2:0] ALU_SLL  = 3'b100;

  // ALU function for any instruction that reaches EXEC; loads/stores add.
  function automatic logic [2:0] alu_sel(input logic [5:0] opc, input logic [5:0] fn);
    logic [2:0] op;
    op = ALU_ADD;
    case (opc)
      OP_RTYPE: begin
        if (fn == FN_SUBU)     op = ALU_SUB;
        else if (fn == FN_SLL) op = ALU_SLL;
        else                   op = ALU_ADD;
      end
      OP_BEQ:  op = ALU_SUB;
      OP_ORI:  op = ALU_OR;
      OP_LUI:  op = ALU_LUI;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mc_ctrl_decode.sv
// mc_decode: combinational opCode/Funct to instruction-class classifier.
`default_nettype none

module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] opCode,
  input  logic [5:0] Funct,
  output iclass_t    iclass
);

  always_comb begin
    iclass = ILLEGAL;
    case (opCode)
      OP_RTYPE: begin
        case (Funct)
          FN_ADDU, FN_SUBU, FN_SLL: iclass = RTYPE_ALU;
          FN_JR:                    iclass = JR;
          default:                  iclass = ILLEGAL;
        endcase
      end
      OP_ORI, OP_LUI: iclass = IMM_ALU;
      OP_LW:          iclass = LOAD;
      OP_SW:          iclass = STORE;
      OP_BEQ:         iclass = BRANCH;
      OP_J:           iclass = JUMP;
      OP_JAL:         iclass = JAL;
      default:        iclass = ILLEGAL;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP).
// Optional performance counters are enabled with MC_CTRL_PERF_EN.
`default_nettype none

module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int RESET_PC_HOLD = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opCode,
  input  logic [5:0] Funct,
  input  logic       aluZero,
  input  logic       memReady,
  output logic       memRead,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       ALUSrc,
  output logic       Branch,
  output logic       MemtoReg,
  output logic       EXTop,
  output logic       Jump,
  output logic       writeR31,
  output logic       JumpToReg,
  output logic [2:0] ALUop,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic [2:0] state,
  output logic       illegal
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [31:0] instrCount,
  output logic [31:0] cycleCount
`endif
);

  localparam int HOLD_W = (RESET_PC_HOLD > 0) ? $clog2(RESET_PC_HOLD + 1) : 1;

  state_t            state_q;
  state_t            state_d;
  iclass_t           iclass;
  logic [HOLD_W-1:0] hold_cnt;
  logic              hold_done;
  logic              alu_phase;
  logic              unused_inputs;

  // The branch decision is taken in the datapath, so the zero flag is not needed here.
  assign unused_inputs = aluZero;

  mc_decode u_decode (
    .opCode (opCode),
    .Funct  (Funct),
    .iclass (iclass)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_FETCH;
      hold_cnt <= HOLD_W'(RESET_PC_HOLD);
    end else begin
      state_q <= state_d;
      if (!hold_done) hold_cnt <= hold_cnt - HOLD_W'(1);
    end
  end

  assign hold_done = (hold_cnt == '0);
  assign state     = state_q;
  // ALU controls stay valid through MEM and WB so address/result are stable.
  assign alu_phase = (state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB);

  always_comb begin
    state_d   = state_q;
    memRead   = 1'b0;
    MemWrite  = 1'b0;
    RegWrite  = 1'b0;
    RegDst    = 1'b0;
    ALUSrc    = 1'b0;
    Branch    = 1'b0;
    MemtoReg  = 1'b0;
    EXTop     = 1'b0;
    Jump      = 1'b0;
    writeR31  = 1'b0;
    JumpToReg = 1'b0;
    ALUop     = ALU_ADD;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    illegal   = 1'b0;

    if (alu_phase) begin
      ALUop  = alu_sel(opCode, Funct);
      ALUSrc = (iclass == IMM_ALU) || (iclass == LOAD) || (iclass == STORE);
      EXTop  = (iclass == LOAD) || (iclass == STORE);
    end

    case (state_q)
      S_FETCH: begin
        memRead = hold_done;
        // IR load is masked while reset is held so no strobe leaks out of reset.
        if (hold_done && memReady && reset) begin
          IRWrite = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (iclass)
          JUMP: begin
            Jump    = 1'b1;
            PCWrite = 1'b1;
            state_d = S_FETCH;
          end
          JAL: begin
            Jump     = 1'b1;
            writeR31 = 1'b1;
            RegWrite = 1'b1;
            PCWrite  = 1'b1;
            state_d  = S_FETCH;
          end
          JR: begin
            JumpToReg = 1'b1;
            PCWrite   = 1'b1;
            state_d   = S_FETCH;
          end
          ILLEGAL: state_d = S_TRAP;
          default: state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (iclass)
          BRANCH: begin
            Branch  = 1'b1;
            PCWrite = 1'b1;
            state_d = S_FETCH;
          end
          LOAD, STORE:        state_d = S_MEM;
          RTYPE_ALU, IMM_ALU: state_d = S_WB;
          default:            state_d = S_TRAP;
        endcase
      end
      S_MEM: begin
        case (iclass)
          LOAD: begin
            memRead = 1'b1;
            if (memReady) state_d = S_WB;
          end
          STORE: begin
            MemWrite = 1'b1;
            if (memReady) begin
              PCWrite = 1'b1;
              state_d = S_FETCH;
            end
          end
          default: state_d = S_TRAP;
        endcase
      end
      S_WB: begin
        RegWrite = 1'b1;
        PCWrite  = 1'b1;
        RegDst   = (iclass == RTYPE_ALU);
        MemtoReg = (iclass == LOAD);
        state_d  = S_FETCH;
      end
      S_TRAP: begin
        illegal = 1'b1;
      end
      default: state_d = S_TRAP;
    endcase

    // Nothing but the trap flag may be driven while trapped.
    if (state_q == S_TRAP) begin
      ALUop  = ALU_ADD;
      ALUSrc = 1'b0;
      EXTop  = 1'b0;
    end
  end

`ifdef MC_CTRL_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instrCount <= 32'd0;
      cycleCount <= 32'd0;
    end else begin
      if (PCWrite) instrCount <= instrCount + 32'd1;
      if (state_q != S_TRAP) cycleCount <= cycleCount + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed-vector scoreboard bench for mc_ctrl.
`default_nettype none

module tb_mc_ctrl;

  localparam logic [5:0] R = 6'h00, J = 6'h02, JALO = 6'h03, BEQ = 6'h04, ORI = 6'h0D,
                         LUI = 6'h0F, LW = 6'h23, SW = 6'h2B, BAD = 6'h3F;
  localparam logic [5:0] F_SLL = 6'h00, F_JR = 6'h08, F_ADDU = 6'h21, F_SUBU = 6'h23;
  localparam logic [2:0] SF = 3'd0, SD = 3'd1, SE = 3'd2, SM = 3'd3, SW_ = 3'd4, ST = 3'd7;
  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AOR = 3'b010, ALUI = 3'b011, ASLL = 3'b100;

  localparam logic [13:0] ILL  = 14'h2000, MRD  = 14'h1000, MWR = 14'h0800, RWR = 14'h0400,
                          RDST = 14'h0200, ASRC = 14'h0100, BR  = 14'h0080, M2R = 14'h0040,
                          EXT  = 14'h0020, JMP  = 14'h0010, W31 = 14'h0008, JRG = 14'h0004,
                          IRW  = 14'h0002, PCW  = 14'h0001, NONE = 14'h0000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [5:0] opCode = 6'h00, Funct = 6'h00;
  logic aluZero = 1'b0, memReady = 1'b0;
  logic memRead, MemWrite, RegWrite, RegDst, ALUSrc, Branch, MemtoReg, EXTop;
  logic Jump, writeR31, JumpToReg, IRWrite, PCWrite, illegal;
  logic [2:0] ALUop, state;
`ifdef MC_CTRL_PERF_EN
  logic [31:0] instrCount, cycleCount;
`endif

  typedef struct {
    logic [19:0] vec;
    string       name;
    bit          pf;
    logic [31:0] ic;
    logic [31:0] cc;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mc_ctrl dut (
    .clk(clk), .reset(reset), .opCode(opCode), .Funct(Funct), .aluZero(aluZero),
    .memReady(memReady), .memRead(memRead), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .RegDst(RegDst), .ALUSrc(ALUSrc), .Branch(Branch), .MemtoReg(MemtoReg), .EXTop(EXTop),
    .Jump(Jump), .writeR31(writeR31), .JumpToReg(JumpToReg), .ALUop(ALUop),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .state(state), .illegal(illegal)
`ifdef MC_CTRL_PERF_EN
    , .instrCount(instrCount), .cycleCount(cycleCount)
`endif
  );

  wire [19:0] act = {state, ALUop, illegal, memRead, MemWrite, RegWrite, RegDst, ALUSrc,
                     Branch, MemtoReg, EXTop, Jump, writeR31, JumpToReg, IRWrite, PCWrite};

  // Monitor: one expected entry per cycle in which the stimulus issued one.
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      checks++;
      if (act !== e.vec) begin
        failures++;
        $display("FAIL %s: got state=%0d vec=%h, expected state=%0d vec=%h",
                 e.name, act[19:17], act, e.vec[19:17], e.vec);
      end
`ifdef MC_CTRL_PERF_EN
      if (e.pf) begin
        checks++;
        if (instrCount !== e.ic || cycleCount !== e.cc) begin
          failures++;
          $display("FAIL %s_perf: got instr=%0d cycle=%0d, expected instr=%0d cycle=%0d",
                   e.name, instrCount, cycleCount, e.ic, e.cc);
        end
      end
`endif
    end
  end

  task automatic push(input logic [2:0] st, input logic [2:0] alu, input logic [13:0] fl,
                      input string nm, input bit pf, input logic [31:0] ic, input logic [31:0] cc);
    exp_t e;
    e.vec = {st, alu, fl};
    e.name = nm;
    e.pf = pf;
    e.ic = ic;
    e.cc = cc;
    sbq.push_back(e);
  endtask

  // Drive one cycle's inputs just after the rising edge and queue its expected outputs.
  task automatic step(input logic [5:0] op, input logic [5:0] fn, input logic rdy,
                      input logic [2:0] st, input logic [2:0] alu, input logic [13:0] fl,
                      input string nm, input bit pf = 1'b0,
                      input logic [31:0] ic = 32'd0, input logic [31:0] cc = 32'd0);
    opCode = op;
    Funct = fn;
    memReady = rdy;
    push(st, alu, fl, nm, pf, ic, cc);
    @(posedge clk);
    #1;
  endtask

  // Assert reset mid-cycle: FETCH must appear before any clock edge.
  task automatic reset_mid(input string nm);
    memReady = 1'b1;
    reset = 1'b0;
    push(SF, ADD, MRD, nm, 1'b0, 32'd0, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // addu with memReady already high on the first FETCH cycle
    step(R, F_ADDU, 1, SF, ADD, MRD | IRW, "addu_fetch");
    step(R, F_ADDU, 1, SD, ADD, NONE, "addu_decode");
    step(R, F_ADDU, 1, SE, ADD, NONE, "addu_exec");
    step(R, F_ADDU, 1, SW_, ADD, RWR | RDST | PCW, "addu_wb");

    // FETCH stall, then subu
    step(R, F_SUBU, 0, SF, ADD, MRD, "fetch_stall");
    step(R, F_SUBU, 1, SF, ADD, MRD | IRW, "subu_fetch");
    step(R, F_SUBU, 0, SD, ADD, NONE, "subu_decode");
    step(R, F_SUBU, 0, SE, SUB, NONE, "subu_exec");
    step(R, F_SUBU, 0, SW_, SUB, RWR | RDST | PCW, "subu_wb");

    // lw with three stalled MEM cycles: 8 cycles total
    step(LW, 6'h00, 1, SF, ADD, MRD | IRW, "lw_fetch");
    step(LW, 6'h00, 1, SD, ADD, NONE, "lw_decode");
    step(LW, 6'h00, 1, SE, ADD, ASRC | EXT, "lw_exec");
    for (int i = 0; i < 3; i++)
      step(LW, 6'h00, 0, SM, ADD, ASRC | EXT | MRD, "lw_mem_stall");
    step(LW, 6'h00, 1, SM, ADD, ASRC | EXT | MRD, "lw_mem_ready");
    step(LW, 6'h00, 0, SW_, ADD, ASRC | EXT | RWR | M2R | PCW, "lw_wb");

    // sw with two stalled MEM cycles
    step(SW, 6'h00, 1, SF, ADD, MRD | IRW, "sw_fetch");
    step(SW, 6'h00, 0, SD, ADD, NONE, "sw_decode");
    step(SW, 6'h00, 0, SE, ADD, ASRC | EXT, "sw_exec");
    for (int i = 0; i < 2; i++)
      step(SW, 6'h00, 0, SM, ADD, ASRC | EXT | MWR, "sw_mem_stall");
    step(SW, 6'h00, 1, SM, ADD, ASRC | EXT | MWR | PCW, "sw_mem_ready");

    // jal and jr: two cycles each
    step(JALO, 6'h00, 1, SF, ADD, MRD | IRW, "jal_fetch");
    step(JALO, 6'h00, 1, SD, ADD, JMP | W31 | RWR | PCW, "jal_decode");
    step(R, F_JR, 1, SF, ADD, MRD | IRW, "jr_fetch");
    step(R, F_JR, 1, SD, ADD, JRG | PCW, "jr_decode");

    // lui and sll
    step(LUI, 6'h00, 1, SF, ADD, MRD | IRW, "lui_fetch");
    step(LUI, 6'h00, 0, SD, ADD, NONE, "lui_decode");
    step(LUI, 6'h00, 0, SE, ALUI, ASRC, "lui_exec");
    step(LUI, 6'h00, 0, SW_, ALUI, ASRC | RWR | PCW, "lui_wb");
    step(R, F_SLL, 1, SF, ADD, MRD | IRW, "sll_fetch");
    step(R, F_SLL, 0, SD, ADD, NONE, "sll_decode");
    step(R, F_SLL, 0, SE, ASLL, NONE, "sll_exec");
    step(R, F_SLL, 0, SW_, ASLL, RWR | RDST | PCW, "sll_wb");

    // sw aborted by reset in MEM: MemWrite drops at once, no PCWrite
    step(SW, 6'h00, 1, SF, ADD, MRD | IRW, "swab_fetch");
    step(SW, 6'h00, 0, SD, ADD, NONE, "swab_decode");
    step(SW, 6'h00, 0, SE, ADD, ASRC | EXT, "swab_exec");
    step(SW, 6'h00, 0, SM, ADD, ASRC | EXT | MWR, "swab_mem");
    reset_mid("swab_reset");

    // unsupported opcode: trap held for 10 cycles regardless of memReady
    step(BAD, 6'h00, 1, SF, ADD, MRD | IRW, "bad_fetch");
    step(BAD, 6'h00, 1, SD, ADD, NONE, "bad_decode");
    for (int i = 0; i < 10; i++)
      step(BAD, 6'h00, i[0], ST, ADD, ILL, "bad_trap");
    reset_mid("trap_reset");

    // unsupported R-type Funct
    step(R, 6'h3F, 1, SF, ADD, MRD | IRW, "badfn_fetch");
    step(R, 6'h3F, 1, SD, ADD, NONE, "badfn_decode");
    step(R, 6'h3F, 1, ST, ADD, ILL, "badfn_trap");
    reset_mid("badfn_reset");

    // beq + ori + j with memReady high: 9 cycles, 3 instructions
    step(BEQ, 6'h00, 1, SF, ADD, MRD | IRW, "beq_fetch", 1'b1, 32'd0, 32'd0);
    step(BEQ, 6'h00, 1, SD, ADD, NONE, "beq_decode");
    step(BEQ, 6'h00, 1, SE, SUB, BR | PCW, "beq_exec");
    step(ORI, 6'h00, 1, SF, ADD, MRD | IRW, "ori_fetch");
    step(ORI, 6'h00, 1, SD, ADD, NONE, "ori_decode");
    step(ORI, 6'h00, 1, SE, AOR, ASRC, "ori_exec");
    step(ORI, 6'h00, 1, SW_, AOR, ASRC | RWR | PCW, "ori_wb");
    step(J, 6'h00, 1, SF, ADD, MRD | IRW, "j_fetch");
    step(J, 6'h00, 1, SD, ADD, JMP | PCW, "j_decode");
    step(R, F_ADDU, 0, SF, ADD, MRD, "final_fetch", 1'b1, 32'd3, 32'd9);

    @(posedge clk);
    #1;
    if (sbq.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
